// File: rtl/usart_rx.sv
// Fixed-format (8N1, LSB first) UART receiver with 16x oversampling,
// glitch rejection on the start bit, framing/overrun reporting and a ready/valid byte output.
module usart_rx (
   input  logic       comm_clock,
   input  logic       reset_n,
   input  logic [11:0] clock_divider,
   input  logic       rx_pin,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       framing_error,
   output logic       overrun_error,
   output logic       bit_clock_x16
);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t     state, state_nxt;
   logic [1:0] sync;
   logic       rx_s, rx_prev;
   logic [7:0] tick_cnt, tick_reload;
   logic       tick;
   logic [3:0] scnt;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic       scnt_clr, sample, complete, ferr;

   assign rx_s          = sync[1];
   assign bit_clock_x16 = tick;

   // A divider below 16 still yields a strobe every cycle.
   assign tick_reload = (clock_divider[11:4] == 8'd0) ? 8'd0 : clock_divider[11:4] - 8'd1;

   always_ff @(posedge comm_clock or negedge reset_n) begin
      if (!reset_n) begin
         sync    <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         sync    <= {sync[0], rx_pin};
         rx_prev <= rx_s;
      end
   end

   // Free-running down counter; the divider is only looked at on reload.
   always_ff @(posedge comm_clock or negedge reset_n) begin
      if (!reset_n) begin
         tick_cnt <= 8'd0;
         tick     <= 1'b0;
      end else if (tick_cnt == 8'd0) begin
         tick_cnt <= tick_reload;
         tick     <= 1'b1;
      end else begin
         tick_cnt <= tick_cnt - 8'd1;
         tick     <= 1'b0;
      end
   end

   always_ff @(posedge comm_clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      scnt_clr  = 1'b0;
      sample    = 1'b0;
      complete  = 1'b0;
      ferr      = 1'b0;
      case (state)
         IDLE:
            if (rx_prev && !rx_s) begin
               state_nxt = START;
               scnt_clr  = 1'b1;
            end
         START:
            if (tick && scnt == 4'd7) begin
               scnt_clr  = 1'b1;
               state_nxt = rx_s ? IDLE : DATA;
            end
         DATA:
            if (tick && scnt == 4'd15) begin
               sample = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end
         STOP:
            if (tick && scnt == 4'd15) begin
               if (rx_s) begin
                  complete  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr      = 1'b1;
                  state_nxt = BREAK;
               end
            end
         BREAK:
            if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // scnt wraps 15 -> 0 on its own, which re-arms the next mid-bit sample.
   always_ff @(posedge comm_clock or negedge reset_n) begin
      if (!reset_n) begin
         scnt    <= 4'd0;
         bit_cnt <= 3'd0;
         shreg   <= 8'd0;
      end else begin
         if (scnt_clr)  scnt <= 4'd0;
         else if (tick) scnt <= scnt + 4'd1;
         if (state != DATA) bit_cnt <= 3'd0;
         else if (sample)   bit_cnt <= bit_cnt + 3'd1;
         if (sample) shreg <= {rx_s, shreg[7:1]};
      end
   end

   always_ff @(posedge comm_clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_data       <= 8'h00;
         rx_valid      <= 1'b0;
         framing_error <= 1'b0;
         overrun_error <= 1'b0;
      end else begin
         framing_error <= ferr;
         overrun_error <= complete && rx_valid && !rx_ready;
         if (complete && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/usart_rx.md
USART_RX -- requirements
Module: usart_rx

Interface
REQ-001 The module SHALL have no parameters; the frame format is fixed at 8 data bits, no parity, 1 stop bit, LSB first.
REQ-002 comm_clock  input  1  Single clock for all logic; rising-edge.
REQ-003 reset_n  input  1  Asynchronous, active-low reset.
REQ-004 clock_divider  input  12  comm_clock cycles per bit period.
REQ-005 rx_pin  input  1  Asynchronous serial line; idles high.
REQ-006 rx_data  output  8  Received byte, held stable while rx_valid is high.
REQ-007 rx_valid  output  1  Byte available in rx_data.
REQ-008 rx_ready  input  1  Consumer accepts rx_data on any cycle where rx_valid and rx_ready are both high.
REQ-009 framing_error  output  1  One-cycle pulse on a bad stop bit.
REQ-010 overrun_error  output  1  One-cycle pulse when a completed byte is dropped.
REQ-011 bit_clock_x16  output  1  One-cycle strobe at 16x the bit rate.

Function
REQ-012 rx_pin SHALL pass through a 2-flop synchronizer; both flops reset to 1; all sampling uses the synchronized value.
REQ-013 The tick counter SHALL strobe bit_clock_x16 every max(clock_divider>>4, 1) comm_clock cycles.
- The counter reloads after each strobe.
- A clock_divider change takes effect at the next reload.
- The counter free-runs in every state.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK; reset state is IDLE.
REQ-015 IDLE -> START on a synchronized falling edge of rx_pin (1 then 0).
- The sample-tick counter is cleared at this transition.
REQ-016 START: on the 8th tick, if the line is high, the FSM SHALL return to IDLE (glitch rejected, no output); if the line is low, it SHALL go to DATA with the sample-tick counter cleared.
REQ-017 DATA: the line SHALL be sampled every 16th tick (mid-bit), LSB first, into an 8-bit shift register.
- After the 8th sample the FSM goes to STOP.
REQ-018 STOP, on the 16th tick:
- Line high: the byte completes and the FSM goes to IDLE.
- Line low: framing_error pulses for 1 cycle, the byte is discarded, and the FSM goes to BREAK.
REQ-019 BREAK SHALL remain until the synchronized line is high, then go to IDLE.
REQ-020 On byte completion, rx_data SHALL load the byte and rx_valid SHALL assert on the next comm_clock edge.
REQ-021 rx_valid SHALL clear on the edge after a cycle with rx_valid && rx_ready, unless a byte completes in that same cycle.
REQ-022 Simultaneous accept and completion: the new byte loads, rx_valid stays high, and there is no overrun.
REQ-023 Completion while rx_valid=1 and rx_ready=0: the new byte is dropped, rx_data keeps the old byte, and overrun_error pulses for 1 cycle.
REQ-024 Error pulses SHALL never exceed one cycle per frame; framing_error and overrun_error are mutually exclusive within a frame.
REQ-025 A falling edge seen in STOP before the 16th tick SHALL be ignored; back-to-back frames are detected from IDLE only.

Reset
REQ-026 While reset_n is low, every output SHALL be driven as follows:
- rx_data = 8'h00.
- rx_valid, framing_error, overrun_error and bit_clock_x16 = 0.
- FSM in IDLE, with tick counter, sample counter and shift register cleared.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output; after release, reception resumes on the next falling edge.

Verification
REQ-028 The bench SHALL cover at least the following directed scenarios:
- clock_divider=32, send 0x55 then 0xA3 at 32 cycles/bit with rx_ready=1 -> rx_data=0x55 then 0xA3, one rx_valid cycle each, no errors; bit_clock_x16 every 2 cycles.
- clock_divider=32, 8-cycle low glitch on idle line -> no rx_valid, no errors, FSM back in IDLE.
- Send 0xA3 with stop bit driven low, then line high after 64 cycles -> framing_error single pulse, rx_valid stays 0, next frame 0x0F received correctly.
- rx_ready=0, send 0x12 then 0x34 -> rx_data stays 0x12, rx_valid held, overrun_error single pulse at 0x34 stop; raise rx_ready -> rx_valid drops after 1 cycle.
- rx_ready pulsed high exactly in the completion cycle of a second byte 0x34 while 0x12 is pending -> rx_data=0x34, rx_valid stays 1, no overrun.
- reset_n low for 3 cycles during bit 4 of 0x7E, then send 0x81 -> no output for 0x7E, rx_data=0x81 received cleanly.
